// File: rtl/rv_mem_exec.sv
// rv_mem_exec: runs the lw/sw/add/sub program held in words START_ADDR..END_ADDR of the shared 16x32 RAM.
// Latency: FETCH to FETCH is 2 cycles for add/sub, 3 for lw, 5 for sw; done/err rise on the edge entering HALT/ERR.
// Backpressure: none; the block owns the RAM port while busy and relies on a combinational RAM read.
module rv_mem_exec #(
    parameter logic [3:0] START_ADDR = 4'd8,
    parameter logic [3:0] END_ADDR   = 4'd15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rw,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  pc,
    input  logic [4:0]  dbg_sel,
    output logic [31:0] dbg_data
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_LOAD,
        S_ST_SET,
        S_ST_WR,
        S_ST_HOLD,
        S_HALT,
        S_ERR
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  pc_nxt;
    logic [31:0] ir;
    logic        ir_ld;
    logic [3:0]  ea_q;
    logic [31:0] sd_q;
    logic        ea_ld;
    logic [31:0] regs [32];
    logic        rf_we;
    logic [31:0] rf_wd;

    // Instruction fields
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        is_lw, is_sw, is_add, is_sub;
    logic [31:0] rs1_val, rs2_val, alu;
    logic [3:0]  imm_lo, ea;
    logic        last;

    assign opcode  = ir[6:0];
    assign rd      = ir[11:7];
    assign f3      = ir[14:12];
    assign rs1     = ir[19:15];
    assign rs2     = ir[24:20];
    assign f7      = ir[31:25];

    assign is_lw   = (opcode == 7'b0000011) && (f3 == 3'b010);
    assign is_sw   = (opcode == 7'b0100011) && (f3 == 3'b010);
    assign is_add  = (opcode == 7'b0110011) && (f3 == 3'b000) && (f7 == 7'b0000000);
    assign is_sub  = (opcode == 7'b0110011) && (f3 == 3'b000) && (f7 == 7'b0100000);

    // x0 is never written, so a plain array read already returns 0 for it
    assign rs1_val = regs[rs1];
    assign rs2_val = regs[rs2];
    assign alu     = is_sub ? (rs1_val - rs2_val) : (rs1_val + rs2_val);

    // Only the low nibble of the address survives, so only the low nibble of the immediate matters
    assign imm_lo  = is_sw ? ir[10:7] : ir[23:20];
    assign ea      = rs1_val[3:0] + imm_lo;
    assign last    = (pc == END_ADDR);

    assign dbg_data = (dbg_sel == 5'd0) ? 32'd0 : regs[dbg_sel];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, RAM port drive and register-file write control
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_ld     = 1'b0;
        ea_ld     = 1'b0;
        rf_we     = 1'b0;
        rf_wd     = alu;
        mem_addr  = 4'd0;
        mem_wdata = 32'd0;
        mem_rw    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_addr  = pc;
                ir_ld     = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                // Address and store data are frozen here so the RAM sees stable values through the store
                ea_ld = 1'b1;
                if (is_add || is_sub) begin
                    rf_we = 1'b1;
                    rf_wd = alu;
                    if (last) begin
                        state_nxt = S_HALT;
                    end else begin
                        pc_nxt    = pc + 4'd1;
                        state_nxt = S_FETCH;
                    end
                end else if (is_lw) begin
                    state_nxt = S_LOAD;
                end else if (is_sw) begin
                    state_nxt = S_ST_SET;
                end else begin
                    state_nxt = S_ERR;
                end
            end
            S_LOAD: begin
                mem_addr = ea_q;
                rf_we    = 1'b1;
                rf_wd    = mem_rdata;
                if (last) begin
                    state_nxt = S_HALT;
                end else begin
                    pc_nxt    = pc + 4'd1;
                    state_nxt = S_FETCH;
                end
            end
            S_ST_SET: begin
                mem_addr  = ea_q;
                mem_wdata = sd_q;
                state_nxt = S_ST_WR;
            end
            S_ST_WR: begin
                mem_addr  = ea_q;
                mem_wdata = sd_q;
                mem_rw    = 1'b1;
                state_nxt = S_ST_HOLD;
            end
            S_ST_HOLD: begin
                mem_addr  = ea_q;
                mem_wdata = sd_q;
                if (last) begin
                    state_nxt = S_HALT;
                end else begin
                    pc_nxt    = pc + 4'd1;
                    state_nxt = S_FETCH;
                end
            end
            S_HALT:  state_nxt = S_HALT;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Program counter, instruction register, latched store operands and registered status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc   <= START_ADDR;
            ir   <= 32'd0;
            ea_q <= 4'd0;
            sd_q <= 32'd0;
            busy <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            pc <= pc_nxt;
            if (ir_ld) ir <= mem_rdata;
            if (ea_ld) begin
                ea_q <= ea;
                sd_q <= rs2_val;
            end
            busy <= (state_nxt != S_IDLE) && (state_nxt != S_HALT) && (state_nxt != S_ERR);
            done <= (state_nxt == S_HALT) || (state_nxt == S_ERR);
            err  <= (state_nxt == S_ERR);
        end
    end

    // Register file write port; writes to x0 are dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (rf_we && (rd != 5'd0)) begin
            regs[rd] <= rf_wd;
        end
    end

endmodule

// File: tb/tb_rv_mem_exec.sv
// tb_rv_mem_exec: drives rv_mem_exec against a bench-owned 16x32 RAM and an instruction-level reference model.
// Latency: checks cycle counts from the start edge to done against fixed vectors and the model.
// Backpressure: none; start is toggled while busy/halted to confirm it is ignored.
module tb_rv_mem_exec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] mem_rdata;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  pc;
    logic [4:0]  dbg_sel;
    logic [31:0] dbg_data;

    always #5 clk = ~clk;

    rv_mem_exec dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rw    (mem_rw),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .pc        (pc),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

    // Bench RAM: combinational read, write while mem_rw is high, bulk load from img
    logic [31:0] ram [16];
    logic [31:0] img [16];
    logic [31:0] std_img [16];
    logic        ld;

    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < 16; i++) ram[i] <= img[i];
        end else if (mem_rw === 1'b1) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    // Write-pulse monitor
    int wr_total = 0;
    int viol     = 0;
    always @(negedge clk) begin
        if (mem_rw === 1'b1) begin
            wr_total++;
            if (busy !== 1'b1) viol++;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Reference model: instruction-by-instruction interpretation of the RAM image
    logic [31:0] m_ram [16];
    logic [31:0] m_x [32];
    int          m_cyc, m_wr;
    logic        m_err;
    logic [3:0]  m_pc;

    task automatic model_run();
        logic [31:0] ins, a, b, imm, ea, res;
        logic [3:0]  p;
        bit          stop;
        for (int i = 0; i < 16; i++) m_ram[i] = img[i];
        for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
        m_cyc = 0; m_wr = 0; m_err = 1'b0; p = 4'd8; stop = 1'b0;
        while (!stop) begin
            ins = m_ram[p];
            a   = m_x[ins[19:15]];
            b   = m_x[ins[24:20]];
            if (ins[6:0] == 7'h03 && ins[14:12] == 3'd2) begin
                imm = {{20{ins[31]}}, ins[31:20]};
                ea  = (a + imm) % 32'd16;
                if (ins[11:7] != 5'd0) m_x[ins[11:7]] = m_ram[ea[3:0]];
                m_cyc += 3;
            end else if (ins[6:0] == 7'h23 && ins[14:12] == 3'd2) begin
                imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                ea  = (a + imm) % 32'd16;
                m_ram[ea[3:0]] = b;
                m_cyc += 5;
                m_wr++;
            end else if (ins[6:0] == 7'h33 && ins[14:12] == 3'd0 &&
                         (ins[31:25] == 7'h00 || ins[31:25] == 7'h20)) begin
                res = (ins[31:25] == 7'h20) ? a - b : a + b;
                if (ins[11:7] != 5'd0) m_x[ins[11:7]] = res;
                m_cyc += 2;
            end else begin
                m_err = 1'b1;
                m_cyc += 2;
                stop  = 1'b1;
            end
            if (!m_err) begin
                if (p == 4'd15) stop = 1'b1;
                else            p = p + 4'd1;
            end
        end
        m_pc = p;
    endtask

    function automatic logic [4:0] pick_reg();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] gen_ins();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [31:0] w;
        rd  = pick_reg();
        rs1 = pick_reg();
        rs2 = pick_reg();
        imm = 12'($urandom);
        case ($urandom_range(0, 9))
            0, 1, 2: w = {imm, rs1, 3'b010, rd, 7'b0000011};
            3, 4:    w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            5, 6:    w = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            7:       w = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            8:       w = {imm, rs1, 3'b000, rd, 7'b0000011};
            default: w = $urandom;
        endcase
        return w;
    endfunction

    task automatic load_reset();
        @(negedge clk);
        rst_n = 1'b0; ld = 1'b1; start = 1'b0;
        @(negedge clk);
        ld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk($sformatf("%s.mem_rw", tag),    32'(mem_rw),    32'd0);
        chk($sformatf("%s.mem_addr", tag),  32'(mem_addr),  32'd0);
        chk($sformatf("%s.mem_wdata", tag), mem_wdata,      32'd0);
        chk($sformatf("%s.busy", tag),      32'(busy),      32'd0);
        chk($sformatf("%s.done", tag),      32'(done),      32'd0);
        chk($sformatf("%s.err", tag),       32'(err),       32'd0);
        chk($sformatf("%s.pc", tag),        32'(pc),        32'd8);
    endtask

    int got_cyc, got_wr;

    // Start the program, count edges to done, then poke start to confirm halt is sticky
    task automatic run_dut(input bit jitter, input string tag);
        int n, wr0;
        @(negedge clk);
        wr0   = wr_total;
        start = 1'b1;
        @(posedge clk);
        #1 start = jitter ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        chk($sformatf("%s.busy_after_start", tag), 32'(busy), 32'd1);
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(posedge clk);
            n++;
            #1 if (jitter) start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        if (done !== 1'b1) chk($sformatf("%s.timeout", tag), 32'(done), 32'd1);
        got_cyc = n;
        chk($sformatf("%s.busy_at_done", tag), 32'(busy), 32'd0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        got_wr = wr_total - wr0;
    endtask

    task automatic chk_vs_model(input string tag);
        chk($sformatf("%s.cycles", tag), got_cyc,   m_cyc);
        chk($sformatf("%s.err", tag),    32'(err),  32'(m_err));
        chk($sformatf("%s.done", tag),   32'(done), 32'd1);
        chk($sformatf("%s.pc", tag),     32'(pc),   32'(m_pc));
        chk($sformatf("%s.writes", tag), got_wr,    m_wr);
        for (int r = 0; r < 32; r++) begin
            dbg_sel = 5'(r);
            #1;
            chk($sformatf("%s.x%0d", tag, r), dbg_data, m_x[r]);
        end
        for (int i = 0; i < 16; i++) chk($sformatf("%s.mem%0d", tag, i), ram[i], m_ram[i]);
    endtask

    typedef struct packed {
        logic        pen;
        logic [3:0]  pidx;
        logic [31:0] pval;
        logic [7:0]  cyc;
        logic        e;
        logic [3:0]  pc;
        logic [3:0]  wr;
        logic [4:0]  ra;
        logic [31:0] rav;
        logic [4:0]  rb;
        logic [31:0] rbv;
        logic [3:0]  mi;
        logic [31:0] mv;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; ld = 1'b0; dbg_sel = 5'd0;

        for (int i = 0; i < 16; i++) std_img[i] = 32'd0;
        std_img[0]  = 32'hFFFFFF8D; std_img[1]  = 32'h21; std_img[2]  = 32'h3A;
        std_img[3]  = 32'h2F;       std_img[4]  = 32'h9F;
        std_img[8]  = 32'h00102283; std_img[9]  = 32'h00202303;
        std_img[10] = 32'h00302383; std_img[11] = 32'h00402403;
        std_img[12] = 32'h006284B3; std_img[13] = 32'h00838533;
        std_img[14] = 32'h40A485B3; std_img[15] = 32'h00B02023;

        //            pen  pidx   pval           cyc   e     pc     wr    ra     rav            rb     rbv            mi    mv
        tbl[0] = '{1'b0, 4'd0,  32'h0,         8'd23, 1'b0, 4'd15, 4'd1, 5'd9,  32'h5B,        5'd11, 32'hFFFFFF8D, 4'd0, 32'hFFFFFF8D};
        tbl[1] = '{1'b1, 4'd15, 32'h00B02223,  8'd23, 1'b0, 4'd15, 4'd1, 5'd10, 32'hCE,        5'd11, 32'hFFFFFF8D, 4'd4, 32'hFFFFFF8D};
        tbl[2] = '{1'b1, 4'd12, 32'h00000013,  8'd14, 1'b1, 4'd12, 4'd0, 5'd9,  32'h0,         5'd8,  32'h9F,       4'd4, 32'h9F};
        tbl[3] = '{1'b1, 4'd12, 32'h00628033,  8'd23, 1'b0, 4'd15, 4'd1, 5'd0,  32'h0,         5'd11, 32'hFFFFFF32, 4'd0, 32'hFFFFFF32};
        tbl[4] = '{1'b1, 4'd9,  32'h0002A303,  8'd23, 1'b0, 4'd15, 4'd1, 5'd6,  32'h21,        5'd11, 32'hFFFFFF74, 4'd0, 32'hFFFFFF74};
        tbl[5] = '{1'b1, 4'd9,  32'h0032A283,  8'd23, 1'b0, 4'd15, 4'd1, 5'd5,  32'h9F,        5'd11, 32'hFFFFFFD1, 4'd0, 32'hFFFFFFD1};
        tbl[6] = '{1'b1, 4'd15, 32'h00000013,  8'd20, 1'b1, 4'd15, 4'd0, 5'd11, 32'hFFFFFF8D,  5'd10, 32'hCE,       4'd0, 32'hFFFFFF8D};
        tbl[7] = '{1'b1, 4'd14, 32'h20A485B3,  8'd18, 1'b1, 4'd14, 4'd0, 5'd11, 32'h0,         5'd10, 32'hCE,       4'd0, 32'hFFFFFF8D};

        // Reset state
        for (int i = 0; i < 16; i++) img[i] = std_img[i];
        load_reset();
        chk_reset_outputs("reset");

        // Directed vectors
        for (int t = 0; t < 8; t++) begin
            string tag;
            tag = $sformatf("vec%0d", t);
            for (int i = 0; i < 16; i++) img[i] = std_img[i];
            if (tbl[t].pen) img[tbl[t].pidx] = tbl[t].pval;
            load_reset();
            model_run();
            run_dut(1'b0, tag);
            chk($sformatf("%s.cyc_const", tag),  got_cyc,       32'(tbl[t].cyc));
            chk($sformatf("%s.err_const", tag),  32'(err),      32'(tbl[t].e));
            chk($sformatf("%s.pc_const", tag),   32'(pc),       32'(tbl[t].pc));
            chk($sformatf("%s.wr_const", tag),   got_wr,        32'(tbl[t].wr));
            dbg_sel = tbl[t].ra;
            #1 chk($sformatf("%s.xa_const", tag), dbg_data, tbl[t].rav);
            dbg_sel = tbl[t].rb;
            #1 chk($sformatf("%s.xb_const", tag), dbg_data, tbl[t].rbv);
            chk($sformatf("%s.mem_const", tag), ram[tbl[t].mi], tbl[t].mv);
            chk_vs_model(tag);
        end

        // Reset asserted during ST_SET of the final store
        begin
            int n, wr0;
            for (int i = 0; i < 16; i++) img[i] = std_img[i];
            img[15] = 32'h00B02223;
            load_reset();
            @(negedge clk);
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            n = 0;
            while (!(pc == 4'd15 && mem_wdata !== 32'd0 && mem_rw === 1'b0) && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) chk("midst.find_st_set", 32'(n), 32'd0);
            wr0   = wr_total;
            rst_n = 1'b0;
            @(negedge clk);
            chk_reset_outputs("midst");
            @(negedge clk);
            rst_n = 1'b1;
            repeat (3) @(negedge clk);
            chk("midst.no_write", wr_total - wr0, 32'd0);
            chk("midst.mem4_kept", ram[4], 32'h9F);
            chk("midst.idle_busy", 32'(busy), 32'd0);
            dbg_sel = 5'd11;
            #1 chk("midst.x11_cleared", dbg_data, 32'd0);
            model_run();
            run_dut(1'b1, "rerun");
            chk("rerun.cyc_const", got_cyc, 32'd23);
            chk("rerun.mem4_const", ram[4], 32'hFFFFFF8D);
            chk_vs_model("rerun");
        end

        // Random programs against the model, with start toggling throughout
        for (int k = 0; k < 25; k++) begin
            for (int i = 0; i < 8; i++)  img[i] = $urandom;
            for (int i = 8; i < 16; i++) img[i] = gen_ins();
            load_reset();
            model_run();
            run_dut(1'b1, $sformatf("rnd%0d", k));
            chk_vs_model($sformatf("rnd%0d", k));
        end

        chk("rw_only_while_busy", viol, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
